// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice:
//   - opcode encodings understood by the shared 32-bit ALU
//   - is_flag_op(): which opcodes produce meaningful C/V outputs
//   - alu_flags_t: packed {Z,N,C,V} flag bundle (Z is the MSB)
//   - arb_state_t: arbiter FSM state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADDC  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUBB  = 4'b0011;
    localparam logic [OP_W-1:0] OP_RSUB  = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0101;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0111;
    localparam logic [OP_W-1:0] OP_PASSA = 4'b1000;
    localparam logic [OP_W-1:0] OP_ADD8  = 4'b1001;
    localparam logic [OP_W-1:0] OP_PASSB = 4'b1010;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    // Only the add/subtract family drives defined carry and overflow outputs.
    function automatic logic is_flag_op(input logic [OP_W-1:0] op);
        return (op <= OP_SUBB);
    endfunction

endpackage

// File: rtl/alu_rsp_buf.sv
// -----------------------------------------------------------------------------
// alu_rsp_buf
// Single-entry result/flag buffer for one requester of the shared ALU.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           an issue for this requester fires this cycle
//   data_in        ALU result to capture
//   flags_in       post-update {Z,N,C,V} to capture
//   rsp_ready      requester consumes the held result
//   rsp_valid      buffer holds a result
//   rsp_out        held result
//   rsp_flags      held {Z,N,C,V}
//   can_accept     buffer can take a new result this cycle (empty or draining)
// -----------------------------------------------------------------------------
module alu_rsp_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic [3:0]   flags_in,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_out,
    output logic [3:0]   rsp_flags,
    output logic         can_accept
);

    logic         valid_q, valid_d;
    logic [W-1:0] out_q, out_d;
    logic [3:0]   flags_q, flags_d;

    // A full buffer that is being consumed this cycle may be refilled in
    // the same cycle.
    assign can_accept = !valid_q || rsp_ready;

    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        flags_d = flags_q;
        if (load) begin
            valid_d = 1'b1;
            out_d   = data_in;
            flags_d = flags_in;
        end else if (rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_out   = out_q;
    assign rsp_flags = flags_q;

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter sharing one combinational 32-bit ALU between two
// requesters (0: execute stage, 1: address/branch unit). Each requester has
// a private {Z,N,C,V} flag register so carry chains never interleave, and a
// single-entry registered result buffer (latency 1).
//
// Optional feature (macro ALU_ARBITER_LOCK_EN): adds req_lock[1:0]. A locked
// issue from requester i holds the arbiter in LOCKi, granting only i, until
// i issues with req_lock[i] = 0 (that issue included).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[1:0]/req_ready   per-requester issue handshake
//   req_op0/1, req_a0/1, req_b0/1  opcode and operands
//   req_lock[1:0]              (ALU_ARBITER_LOCK_EN only) lock request
//   rsp_valid[1:0]/rsp_ready   per-requester result handshake
//   rsp_out0/1, rsp_flags0/1   registered result and {Z,N,C,V}
//   alu_a, alu_b, alu_op, alu_ci   drive to the ALU
//   alu_out, alu_z/n/c/v           results from the ALU
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_b1,
`ifdef ALU_ARBITER_LOCK_EN
    input  logic [1:0]     req_lock,
`endif
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_out0,
    output logic [W-1:0]   rsp_out1,
    output logic [3:0]     rsp_flags0,
    output logic [3:0]     rsp_flags1,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    output logic           alu_ci,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_z,
    input  logic           alu_n,
    input  logic           alu_c,
    input  logic           alu_v
);

    arb_state_t state_q, state_d;
    logic       prio_q, prio_d;      // requester preferred on the next tie
    alu_flags_t flags0_q, flags0_d;
    alu_flags_t flags1_q, flags1_d;

    logic [1:0] can_accept;
    logic [1:0] allow;
    logic [1:0] elig;
    logic [1:0] gnt;
    alu_flags_t cur_flags;
    alu_flags_t upd_flags;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
`ifdef ALU_ARBITER_LOCK_EN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (gnt[0] && req_lock[0]) begin
                    state_d = ST_LOCK0;
                end else if (gnt[1] && req_lock[1]) begin
                    state_d = ST_LOCK1;
                end
            end
            ST_LOCK0: begin
                if (gnt[0] && !req_lock[0]) begin
                    state_d = ST_ARB;
                end
            end
            ST_LOCK1: begin
                if (gnt[1] && !req_lock[1]) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end
`else
    always_comb begin
        state_d = ST_ARB;
    end
`endif

    // ------------------------------------------------------------------
    // FSM: outputs (which requesters may be granted in this state)
    // ------------------------------------------------------------------
    always_comb begin
        allow = 2'b11;
        case (state_q)
            ST_LOCK0: allow = 2'b01;
            ST_LOCK1: allow = 2'b10;
            default:  allow = 2'b11;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant: round-robin among valid requesters whose buffer can accept
    // ------------------------------------------------------------------
    always_comb begin
        elig = req_valid & can_accept & allow;
        gnt  = elig;
        if (elig == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
    end

    // The grant already includes valid and buffer space, so a granted
    // requester's issue fires this cycle.
    assign req_ready = gnt;

    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // ALU operand mux; idle drives all-zero (ADD 0+0, carry-in 0)
    // ------------------------------------------------------------------
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        cur_flags = '0;
        if (gnt[0]) begin
            alu_a     = req_a0;
            alu_b     = req_b0;
            alu_op    = req_op0;
            cur_flags = flags0_q;
        end else if (gnt[1]) begin
            alu_a     = req_a1;
            alu_b     = req_b1;
            alu_op    = req_op1;
            cur_flags = flags1_q;
        end
    end

    assign alu_ci = cur_flags.c;

    // ------------------------------------------------------------------
    // Flag update: Z/N always follow the ALU; C/V only from add/sub ops,
    // since the ALU leaves them undefined for everything else.
    // ------------------------------------------------------------------
    always_comb begin
        upd_flags.z = alu_z;
        upd_flags.n = alu_n;
        upd_flags.c = cur_flags.c;
        upd_flags.v = cur_flags.v;
        if (is_flag_op(alu_op)) begin
            upd_flags.c = alu_c;
            upd_flags.v = alu_v;
        end
    end

    always_comb begin
        flags0_d = gnt[0] ? upd_flags : flags0_q;
        flags1_d = gnt[1] ? upd_flags : flags1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q   <= 1'b0;
            flags0_q <= '0;
            flags1_q <= '0;
        end else begin
            prio_q   <= prio_d;
            flags0_q <= flags0_d;
            flags1_q <= flags1_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-requester result buffers
    // ------------------------------------------------------------------
    alu_rsp_buf #(.W(W)) u_buf0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gnt[0]),
        .data_in    (alu_out),
        .flags_in   (upd_flags),
        .rsp_ready  (rsp_ready[0]),
        .rsp_valid  (rsp_valid[0]),
        .rsp_out    (rsp_out0),
        .rsp_flags  (rsp_flags0),
        .can_accept (can_accept[0])
    );

    alu_rsp_buf #(.W(W)) u_buf1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gnt[1]),
        .data_in    (alu_out),
        .flags_in   (upd_flags),
        .rsp_ready  (rsp_ready[1]),
        .rsp_valid  (rsp_valid[1]),
        .rsp_out    (rsp_out1),
        .rsp_flags  (rsp_flags1),
        .can_accept (can_accept[1])
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
// Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [OPW-1:0] req_op0, req_op1;
    logic [W-1:0]   req_a0, req_a1, req_b0, req_b1;
`ifdef ALU_ARBITER_LOCK_EN
    logic [1:0]     req_lock;
`endif
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_out0, rsp_out1;
    logic [3:0]     rsp_flags0, rsp_flags1;
    logic [W-1:0]   alu_a, alu_b;
    logic [OPW-1:0] alu_op;
    logic           alu_ci;
    logic [W-1:0]   alu_out;
    logic           alu_z, alu_n, alu_c, alu_v;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
`ifdef ALU_ARBITER_LOCK_EN
        .req_lock   (req_lock),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out0   (rsp_out0),
        .rsp_out1   (rsp_out1),
        .rsp_flags0 (rsp_flags0),
        .rsp_flags1 (rsp_flags1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_ci     (alu_ci),
        .alu_out    (alu_out),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_c      (alu_c),
        .alu_v      (alu_v)
    );

    // Behavioural ALU. C is carry-out (no-borrow for subtracts); C/V are
    // driven 0 for non add/sub ops so any wrongful capture shows up.
    logic [W:0] sum;
    always_comb begin
        sum   = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            OP_ADD:   sum = {1'b0, alu_a} + {1'b0, alu_b};
            OP_ADDC:  sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ci};
            OP_SUB:   sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
            OP_SUBB:  sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_ci};
            OP_RSUB:  sum = {1'b0, alu_b} + {1'b0, ~alu_a} + {{W{1'b0}}, 1'b1};
            OP_OR:    sum = {1'b0, alu_a | alu_b};
            OP_XOR:   sum = {1'b0, alu_a ^ alu_b};
            OP_AND:   sum = {1'b0, alu_a & alu_b};
            OP_PASSA: sum = {1'b0, alu_a};
            OP_ADD8:  sum = {1'b0, alu_a + {{(W-8){1'b0}}, alu_b[7:0]}};
            OP_PASSB: sum = {1'b0, alu_b};
            default:  sum = '0;
        endcase
        alu_out = sum[W-1:0];
        alu_z   = (alu_out == '0);
        alu_n   = alu_out[W-1];
        if (alu_op == OP_ADD || alu_op == OP_ADDC) begin
            alu_c = sum[W];
            alu_v = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
        end else if (alu_op == OP_SUB || alu_op == OP_SUBB) begin
            alu_c = sum[W];
            alu_v = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op0 = op;
        req_a0  = a;
        req_b0  = b;
    endtask

    task automatic set1(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op1 = op;
        req_a1  = a;
        req_b1  = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set0(OP_ADD, '0, '0);
        set1(OP_ADD, '0, '0);
`ifdef ALU_ARBITER_LOCK_EN
        req_lock  = 2'b00;
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_out0", rsp_out0, 0);
        check("rst_flags1", rsp_flags1, 4'b0000);
        check("rst_req_ready", req_ready, 2'b00);
        check("idle_alu_op", alu_op, 0);
        check("idle_alu_ci", alu_ci, 1'b0);

        // ADD on req0
        step();
        set0(OP_ADD, 32'h9C00_0038, 32'h7000_0003);
        req_valid = 2'b01;
        #1;
        check("add_req_ready", req_ready, 2'b01);
        check("add_alu_a", alu_a, 32'h9C00_0038);
        step();
        req_valid = 2'b00;
        check("add_rsp_valid", rsp_valid, 2'b01);
        check("add_out0", rsp_out0, 32'h0C00_003B);
        check("add_flags0", rsp_flags0, 4'b0010);

        // SUB on req0, carry-in from the ADD is visible on alu_ci
        set0(OP_SUB, 32'h9C00_0038, 32'h7000_0003);
        req_valid = 2'b01;
        #1;
        check("sub_alu_ci", alu_ci, 1'b1);
        step();
        req_valid = 2'b00;
        check("sub_out0", rsp_out0, 32'h2C00_0035);
        check("sub_flags0", rsp_flags0, 4'b0011);

        // OR keeps C/V from the SUB
        set0(OP_OR, 32'h9C00_0038, 32'h7000_0003);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("or_out0", rsp_out0, 32'hFC00_003B);
        check("or_flags0", rsp_flags0, 4'b0111);

        // Undefined opcode: result 0, Z=1 N=0, C/V unchanged
        set0(4'b1111, 32'h1234_5678, 32'h1);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("op15_out0", rsp_out0, 0);
        check("op15_flags0", rsp_flags0, 4'b1011);

        // Carry isolation
        set0(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("ciso_add_out0", rsp_out0, 0);
        check("ciso_add_flags0", rsp_flags0, 4'b1010);
        set1(OP_ADDC, 32'h1, 32'h1);
        req_valid = 2'b10;
        #1;
        check("ciso_req1_ci", alu_ci, 1'b0);
        step();
        req_valid = 2'b00;
        check("ciso_out1", rsp_out1, 32'h2);
        check("ciso_flags1", rsp_flags1, 4'b0000);
        set0(OP_ADDC, 32'h1, 32'h1);
        req_valid = 2'b01;
        #1;
        check("ciso_req0_ci", alu_ci, 1'b1);
        step();
        req_valid = 2'b00;
        check("ciso_out0", rsp_out0, 32'h3);
        check("ciso_flags0", rsp_flags0, 4'b0000);
        step();
        check("drain_rsp_valid", rsp_valid, 2'b00);

        // Alternation: last grant was req0, so req1 leads
        set0(OP_PASSA, 32'h100, 32'h0);
        set1(OP_PASSA, 32'h200, 32'h0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_req_ready", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            step();
            check("alt_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        check("alt_out0", rsp_out0, 32'h100);
        check("alt_out1", rsp_out1, 32'h200);
        req_valid = 2'b00;
        step();

        // Backpressure on buffer 0
        rsp_ready = 2'b10;
        set0(OP_PASSA, 32'h11, 32'h0);
        req_valid = 2'b01;
        step();
        set0(OP_PASSA, 32'h22, 32'h0);
        set1(OP_PASSA, 32'h33, 32'h0);
        req_valid = 2'b11;
        check("bp_first_out0", rsp_out0, 32'h11);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("bp_req_ready", req_ready, 2'b10);
            step();
            check("bp_hold_out0", rsp_out0, 32'h11);
            check("bp_out1", rsp_out1, 32'h33);
        end
        rsp_ready = 2'b11;
        #1;
        check("bp_refill_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        check("bp_refill_valid", rsp_valid[0], 1'b1);
        check("bp_refill_out0", rsp_out0, 32'h22);
        rsp_ready = 2'b11;
        step();
        step();

`ifdef ALU_ARBITER_LOCK_EN
        // Locked ADD then unlocked ADDC; req1 waits until after the ADDC
        set0(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        req_lock  = 2'b01;
        req_valid = 2'b01;
        #1;
        check("lock_first_ready", req_ready, 2'b01);
        step();
        set0(OP_ADDC, 32'h1, 32'h1);
        set1(OP_PASSA, 32'h44, 32'h0);
        req_lock  = 2'b00;
        req_valid = 2'b11;
        #1;
        check("lock_hold_ready", req_ready, 2'b01);
        check("lock_ci", alu_ci, 1'b1);
        step();
        req_valid = 2'b10;
        #1;
        check("lock_release_ready", req_ready, 2'b10);
        check("lock_out0", rsp_out0, 32'h3);
        req_valid = 2'b00;
        step();
        step();
`endif

        // Asynchronous reset mid-stream
        set0(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("pre_rst_valid", rsp_valid, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", rsp_valid, 2'b00);
        check("async_rst_flags0", rsp_flags0, 4'b0000);
        #2 rst_n = 1'b1;
        step();
        set0(OP_PASSA, 32'h55, 32'h0);
        set1(OP_PASSA, 32'h66, 32'h0);
        req_valid = 2'b11;
        #1;
        check("post_rst_ptr", req_ready, 2'b01);
        check("post_rst_ci", alu_ci, 1'b0);
        step();
        req_valid = 2'b00;
        check("post_rst_out0", rsp_out0, 32'h55);
        check("post_rst_flags0", rsp_flags0, 4'b0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
